// File: rtl/sha256_nblock_in.sv
// Multi-chunk SHA-256 front end: feeds NUM_BLOCKS pre-padded 512-bit chunks through one iterative core.
// Optional job cancel (abort_i port plus DRAIN state) is compiled in with `define SHA256_NBLOCK_ABORT_EN.

module sha256 (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         new_hash,
    input  logic         in_valid,
    input  logic [511:0] in,
    output logic         in_ready,
    output logic         out_valid,
    output logic [255:0] out,
    input  logic         out_ready
);
    localparam logic [7:0][31:0] IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                       32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] k_of(input logic [5:0] t);
        logic [31:0] k;
        case (t)
            6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7; 6'd63: k = 32'hc67178f2;
            default: k = 32'h0;
        endcase
        return k;
    endfunction

    logic              run_r;
    logic [5:0]        round_r;
    logic [7:0][31:0]  st_r;
    logic [7:0][31:0]  hv_r;
    logic [15:0][31:0] w_r;
    logic              out_valid_r;

    logic [7:0][31:0]  base_s;
    logic [7:0][31:0]  st_next_s;
    logic [7:0][31:0]  sum_s;
    logic [15:0][31:0] words_s;
    logic [31:0]       t1_s;
    logic [31:0]       t2_s;
    logic [31:0]       w_next_s;

    // One compression round per cycle; w_r is a 16-word sliding schedule window with W[t] at index 0.
    always_comb begin
        base_s = new_hash ? IV : hv_r;
        words_s = '0;
        for (int j = 0; j < 16; j++) begin
            words_s[j] = in[511 - 32*j -: 32];
        end
        t1_s = st_r[7] + big_s1(st_r[4]) + ((st_r[4] & st_r[5]) ^ (~st_r[4] & st_r[6]))
             + k_of(round_r) + w_r[0];
        t2_s = big_s0(st_r[0]) + ((st_r[0] & st_r[1]) ^ (st_r[0] & st_r[2]) ^ (st_r[1] & st_r[2]));
        st_next_s = {st_r[6:0], t1_s + t2_s};
        st_next_s[4] = st_r[3] + t1_s;
        w_next_s = small_s1(w_r[14]) + w_r[9] + small_s0(w_r[1]) + w_r[0];
        sum_s = '0;
        for (int j = 0; j < 8; j++) begin
            sum_s[j] = hv_r[j] + st_next_s[j];
        end
    end

    // Digest word 0 is the most significant word of out.
    always_comb begin
        out = '0;
        for (int j = 0; j < 8; j++) begin
            out[255 - 32*j -: 32] = hv_r[j];
        end
    end

    // Core sequencing: accepting a chunk overwrites any unconsumed result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_r       <= 1'b0;
            round_r     <= 6'd0;
            st_r        <= '0;
            hv_r        <= '0;
            w_r         <= '0;
            out_valid_r <= 1'b0;
        end else if (run_r) begin
            st_r    <= st_next_s;
            w_r     <= {w_next_s, w_r[15:1]};
            round_r <= round_r + 6'd1;
            if (round_r == 6'd63) begin
                run_r       <= 1'b0;
                hv_r        <= sum_s;
                out_valid_r <= 1'b1;
            end
        end else if (in_valid) begin
            st_r        <= base_s;
            hv_r        <= base_s;
            w_r         <= words_s;
            round_r     <= 6'd0;
            run_r       <= 1'b1;
            out_valid_r <= 1'b0;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = ~run_r;
    assign out_valid = out_valid_r;
endmodule

module sha256_nblock_in #(
    parameter int NUM_BLOCKS = 2,
    parameter int IN_W       = NUM_BLOCKS * 512
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [IN_W-1:0] in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [255:0]    out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
`ifdef SHA256_NBLOCK_ABORT_EN
    ,
    input  logic            abort_i
`endif
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3
`ifdef SHA256_NBLOCK_ABORT_EN
        ,
        DRAIN = 3'd4
`endif
    } state_t;

    logic abort_s;
`ifdef SHA256_NBLOCK_ABORT_EN
    localparam state_t ABORT_DST = DRAIN;
    assign abort_s = abort_i;
`else
    localparam state_t ABORT_DST = IDLE;
    assign abort_s = 1'b0;
`endif

    state_t          state_r;
    logic [2:0]      blk_r;
    logic [IN_W-1:0] in_reg_r;
    logic [255:0]    out_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;

    logic            core_in_valid_s;
    logic            core_new_hash_s;
    logic            core_out_ready_s;
    logic            core_in_ready_s;
    logic            core_out_valid_s;
    logic [255:0]    core_out_s;
    logic [511:0]    chunk_a [8];

    for (genvar k = 0; k < 8; k++) begin : g_chunk
        if (k < NUM_BLOCKS) begin : g_on
            assign chunk_a[k] = in_reg_r[IN_W - 1 - 512*k -: 512];
        end else begin : g_off
            assign chunk_a[k] = '0;
        end
    end

    // Core handshakes; in LOAD for later chunks out_ready consumes the intermediate state.
    always_comb begin
        core_in_valid_s  = (state_r == LOAD);
        core_new_hash_s  = (state_r == LOAD) && (blk_r == 3'd0);
        core_out_ready_s = ((state_r == LOAD) && (blk_r != 3'd0)) || (state_r == OUT)
`ifdef SHA256_NBLOCK_ABORT_EN
                         || (state_r == DRAIN)
`endif
                         ;
    end

    sha256 u_core (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .new_hash  (core_new_hash_s),
        .in_valid  (core_in_valid_s),
        .in        (chunk_a[blk_r]),
        .in_ready  (core_in_ready_s),
        .out_valid (core_out_valid_s),
        .out       (core_out_s),
        .out_ready (core_out_ready_s)
    );

    // Job sequencer with registered handshake outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            blk_r       <= 3'd0;
            in_reg_r    <= '0;
            out_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        in_reg_r   <= in;
                        blk_r      <= 3'd0;
                        state_r    <= LOAD;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort_s && !core_in_ready_s) begin
                        state_r    <= IDLE;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end else if (abort_s) begin
                        state_r <= ABORT_DST;
                    end else if (core_in_ready_s) begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort_s) begin
                        state_r <= ABORT_DST;
                    end else if (core_out_valid_s) begin
                        if (blk_r == 3'(NUM_BLOCKS - 1)) begin
                            out_r       <= core_out_s;
                            out_valid_r <= 1'b1;
                            state_r     <= OUT;
                        end else begin
                            blk_r   <= blk_r + 3'd1;
                            state_r <= LOAD;
                        end
                    end
                end
                OUT: begin
                    if (abort_s || out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
`ifdef SHA256_NBLOCK_ABORT_EN
                DRAIN: begin
                    if (core_out_valid_s) begin
                        state_r    <= IDLE;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r & ~rst_i;
    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
endmodule

// File: tb/tb_sha256_nblock_in.sv
// Bench for sha256_nblock_in: one- and two-chunk instances checked against a behavioural SHA-256 model.
module tb_sha256_nblock_in;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [511:0]  in1;
    logic          iv1, ir1, ov1, or1, busy1;
    logic [255:0]  out1;
    logic [1023:0] in2;
    logic          iv2, ir2, ov2, or2, busy2, ab2;
    logic [255:0]  out2;
    logic          chk2;

    int n_chk = 0;
    int n_fail = 0;

    logic [255:0] q1 [$];
    logic [255:0] q2 [$];

    sha256_nblock_in #(.NUM_BLOCKS(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .in(in1), .in_valid(iv1), .in_ready(ir1),
        .out(out1), .out_valid(ov1), .out_ready(or1), .busy(busy1)
`ifdef SHA256_NBLOCK_ABORT_EN
        , .abort_i(1'b0)
`endif
    );

    sha256_nblock_in #(.NUM_BLOCKS(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .in(in2), .in_valid(iv2), .in_ready(ir2),
        .out(out2), .out_valid(ov2), .out_ready(or2), .busy(busy2)
`ifdef SHA256_NBLOCK_ABORT_EN
        , .abort_i(ab2)
`endif
    );

    logic [31:0] ktab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // Straight FIPS 180-4 hash of nb chunks taken from the top of the low nb*512 bits of m.
    function automatic logic [255:0] model(input logic [1023:0] m, input int nb);
        logic [31:0] h [8];
        logic [31:0] v [8];
        logic [31:0] w [64];
        logic [31:0] t1, t2, s0, s1;
        logic [511:0] blk;
        h[0] = 32'h6a09e667; h[1] = 32'hbb67ae85; h[2] = 32'h3c6ef372; h[3] = 32'ha54ff53a;
        h[4] = 32'h510e527f; h[5] = 32'h9b05688c; h[6] = 32'h1f83d9ab; h[7] = 32'h5be0cd19;
        for (int k = 0; k < nb; k++) begin
            blk = m[nb*512 - 1 - 512*k -: 512];
            for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
            for (int t = 16; t < 64; t++) begin
                s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = s1 + w[t-7] + s0 + w[t-16];
            end
            for (int j = 0; j < 8; j++) v[j] = h[j];
            for (int t = 0; t < 64; t++) begin
                t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + ktab[t] + w[t];
                t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
                   + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                for (int j = 7; j > 0; j--) v[j] = v[j-1];
                v[4] = v[4] + t1;
                v[0] = t1 + t2;
            end
            for (int j = 0; j < 8; j++) h[j] = h[j] + v[j];
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Compare process: every cycle out of reset, handshakes and digests versus the job queues.
    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
            q2.delete();
        end else begin
            check("busy1", busy1, q1.size() != 0);
            check("in_ready1", ir1, q1.size() == 0);
            if (ov1) begin
                if (q1.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL spurious_out1: out_valid 1 with no job, expected 0");
                end else check("digest1", out1, q1[0]);
            end
            if (ov1 && or1 && q1.size() != 0) void'(q1.pop_front());
            if (iv1 && ir1) q1.push_back(model({512'b0, in1}, 1));

            if (chk2) begin
                check("busy2", busy2, q2.size() != 0);
                check("in_ready2", ir2, q2.size() == 0);
            end
            if (ov2) begin
                if (q2.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL spurious_out2: out_valid 1 with no job, expected 0");
                end else check("digest2", out2, q2[0]);
            end
            if (ab2) q2.delete();
            if (ov2 && or2 && q2.size() != 0) void'(q2.pop_front());
            if (iv2 && ir2) q2.push_back(model(in2, 2));
        end
    end

    task automatic send1(input logic [511:0] m, input bit keep);
        int n = 0;
        @(posedge clk); #1; in1 = m; iv1 = 1'b1;
        @(negedge clk);
        while (!ir1 && n < 300) begin @(negedge clk); n++; end
        n_chk++;
        if (!ir1) begin n_fail++; $display("FAIL send1_timeout: in_ready %b, expected 1", ir1); end
        @(posedge clk); #1;
        if (!keep) iv1 = 1'b0;
    endtask

    task automatic send2(input logic [1023:0] m);
        int n = 0;
        @(posedge clk); #1; in2 = m; iv2 = 1'b1;
        @(negedge clk);
        while (!ir2 && n < 300) begin @(negedge clk); n++; end
        n_chk++;
        if (!ir2) begin n_fail++; $display("FAIL send2_timeout: in_ready %b, expected 1", ir2); end
        @(posedge clk); #1; iv2 = 1'b0;
    endtask

    task automatic recv1(input logic [255:0] exp, input int hold, input string nm);
        int n = 0;
        @(negedge clk);
        while (!ov1 && n < 400) begin @(negedge clk); n++; end
        if (!ov1) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: out_valid %b, expected 1", nm, ov1);
        end else begin
            check(nm, out1, exp);
            repeat (hold) begin
                @(negedge clk);
                check({nm, "_stable"}, out1, exp);
                check({nm, "_held"}, ov1, 1'b1);
                check({nm, "_noready"}, ir1, 1'b0);
            end
        end
        @(posedge clk); #1; or1 = 1'b1;
        @(posedge clk); #1; or1 = 1'b0;
    endtask

    task automatic recv2(input logic [255:0] exp, input int hold, input string nm);
        int n = 0;
        @(negedge clk);
        while (!ov2 && n < 400) begin @(negedge clk); n++; end
        if (!ov2) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: out_valid %b, expected 1", nm, ov2);
        end else begin
            check(nm, out2, exp);
            repeat (hold) begin
                @(negedge clk);
                check({nm, "_stable"}, out2, exp);
                check({nm, "_held"}, ov2, 1'b1);
            end
        end
        @(posedge clk); #1; or2 = 1'b1;
        @(posedge clk); #1; or2 = 1'b0;
    endtask

    logic [511:0]  abc_m, empty_m;
    logic [1023:0] msg2_m;
    logic [255:0]  lit_abc, lit_empty, lit2;

    initial begin
        rst = 1'b1; in1 = '0; iv1 = 1'b0; or1 = 1'b0; in2 = '0; iv2 = 1'b0; or2 = 1'b0; ab2 = 1'b0; chk2 = 1'b1;
        abc_m = '0; abc_m[511:488] = "abc"; abc_m[487] = 1'b1; abc_m[63:0] = 64'd24;
        empty_m = '0; empty_m[511] = 1'b1;
        msg2_m = '0;
        msg2_m[1023:576] = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        msg2_m[575] = 1'b1; msg2_m[63:0] = 64'd448;
        lit_abc   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        lit_empty = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
        lit2      = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

        check("model_abc", model({512'b0, abc_m}, 1), lit_abc);
        check("model_empty", model({512'b0, empty_m}, 1), lit_empty);
        check("model_two_chunk", model(msg2_m, 2), lit2);

        repeat (3) @(negedge clk);
        check("rst_in_ready1", ir1, 1'b0);
        check("rst_out_valid1", ov1, 1'b0);
        check("rst_busy1", busy1, 1'b0);
        check("rst_out1", out1, 256'h0);
        check("rst_in_ready2", ir2, 1'b0);
        check("rst_busy2", busy2, 1'b0);
        check("rst_out2", out2, 256'h0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready1", ir1, 1'b1);
        check("post_rst_ready2", ir2, 1'b1);

        send1(abc_m, 1'b0);      recv1(lit_abc, 5, "abc_nb1");
        send1(empty_m, 1'b0);    recv1(lit_empty, 0, "empty_nb1");
        send2(msg2_m);           recv2(lit2, 3, "two_chunk_nb2");

        // Back-to-back jobs with in_valid held and a slow consumer on the first.
        send1(abc_m, 1'b1);
        recv1(lit_abc, 10, "b2b_first");
        @(negedge clk);
        check("b2b_ready_next", ir1, 1'b1);
        @(posedge clk); #1; iv1 = 1'b0;
        recv1(lit_abc, 0, "b2b_second");

        // Reset during the second chunk.
        send2(msg2_m);
        repeat (80) @(posedge clk);
        #1; rst = 1'b1; #1;
        check("midrst_busy2", busy2, 1'b0);
        check("midrst_out_valid2", ov2, 1'b0);
        check("midrst_in_ready2", ir2, 1'b0);
        @(negedge clk);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", ir2, 1'b1);
        send1(abc_m, 1'b0);      recv1(lit_abc, 0, "abc_after_rst");
        send2(msg2_m);           recv2(lit2, 0, "two_chunk_after_rst");

        // in_valid and in churn while busy must not disturb the captured message.
        send2(msg2_m);
        repeat (20) begin
            @(posedge clk); #1; iv2 = ~iv2; in2 = {abc_m, abc_m};
        end
        iv2 = 1'b0;
        recv2(lit2, 0, "busy_churn");

`ifdef SHA256_NBLOCK_ABORT_EN
        send2(msg2_m);
        repeat (10) @(posedge clk);
        #1; chk2 = 1'b0; ab2 = 1'b1;
        @(posedge clk); #1; ab2 = 1'b0;
        @(negedge clk);
        check("drain_busy", busy2, 1'b1);
        begin
            int n = 0;
            while (busy2 && n < 200) begin @(negedge clk); n++; end
        end
        check("drain_done", busy2, 1'b0);
        check("drain_ready", ir2, 1'b1);
        chk2 = 1'b1;
        send2(msg2_m);           recv2(lit2, 0, "after_abort");
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
